// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU select codes,
// FSM state encodings, the issue command record and the latency lookup.
package alu_ctrl_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] OP_FWD  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MULT = 3'd4;
    localparam logic [2:0] OP_SL   = 3'd5;
    localparam logic [2:0] OP_SR   = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data1;
        logic [7:0] data2;
    } alu_cmd_t;

    // EXEC cycle count for an op; code 7 falls into the basic class.
    function automatic logic [CNT_W-1:0] lat_cycles(
        input logic [2:0]  op,
        input int unsigned lat_basic,
        input int unsigned lat_shift,
        input int unsigned lat_mult
    );
        logic [CNT_W-1:0] lat;
        lat = CNT_W'(lat_basic);
        case (op)
            OP_MULT:      lat = CNT_W'(lat_mult);
            OP_SL, OP_SR: lat = CNT_W'(lat_shift);
            default:      lat = CNT_W'(lat_basic);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic; the pointer is owned by the caller.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    // ptr == 0 favours requester 0, ptr == 1 favours requester 1.
    always_comb begin
        gnt[0] = en & req[0] & (~req[1] | ~ptr);
        gnt[1] = en & req[1] & (~req[0] |  ptr);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters: accepts one op at a time,
// holds the ALU inputs for the op's latency, then returns RESULT/ZERO.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned LAT_BASIC = 1,
    parameter int unsigned LAT_SHIFT = 2,
    parameter int unsigned LAT_MULT  = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [2:0] REQ0_OP,
    input  logic [7:0] REQ0_A,
    input  logic [7:0] REQ0_B,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [2:0] REQ1_OP,
    input  logic [7:0] REQ1_A,
    input  logic [7:0] REQ1_B,
    output logic       RSP0_VALID,
    input  logic       RSP0_READY,
    output logic       RSP1_VALID,
    input  logic       RSP1_READY,
    output logic [7:0] RSP_RESULT,
    output logic       RSP_ZERO,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             owner_q,  owner_d;
    logic             ptr_q,    ptr_d;
    alu_cmd_t         cmd_q,    cmd_d;
    logic [7:0]       result_q, result_d;
    logic             zero_q,   zero_d;

    logic [1:0]       gnt;
    logic             arb_en;
    alu_cmd_t         win_cmd;
    logic             owner_rsp_ready;

    // Grants are gated by reset so READY is 0 while RESET is asserted.
    assign arb_en = (state_q == ST_IDLE) && RESET;

    rr_arbiter_2 u_rr (
        .req (
            {REQ1_VALID, REQ0_VALID}
        ),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign win_cmd = gnt[1] ? '{sel: REQ1_OP, data1: REQ1_A, data2: REQ1_B}
                            : '{sel: REQ0_OP, data1: REQ0_A, data2: REQ0_B};
    assign owner_rsp_ready = owner_q ? RSP1_READY : RSP0_READY;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cmd_d    = cmd_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1];
                    cmd_d   = win_cmd;
                    cnt_d   = lat_cycles(win_cmd.sel, LAT_BASIC, LAT_SHIFT, LAT_MULT) - CNT_ONE;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = ALU_RESULT;
                    zero_d   = ALU_ZERO;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    ptr_d   = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            cmd_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign RSP0_VALID = (state_q == ST_RESP) && !owner_q;
    assign RSP1_VALID = (state_q == ST_RESP) &&  owner_q;
    assign RSP_RESULT = result_q;
    assign RSP_ZERO   = zero_q;
    assign ALU_SELECT = cmd_q.sel;
    assign ALU_DATA1  = cmd_q.data1;
    assign ALU_DATA2  = cmd_q.data2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;

    logic       CLK;
    logic       RESET;
    logic       REQ0_VALID, REQ0_READY;
    logic [2:0] REQ0_OP;
    logic [7:0] REQ0_A, REQ0_B;
    logic       REQ1_VALID, REQ1_READY;
    logic [2:0] REQ1_OP;
    logic [7:0] REQ1_A, REQ1_B;
    logic       RSP0_VALID, RSP0_READY;
    logic       RSP1_VALID, RSP1_READY;
    logic [7:0] RSP_RESULT;
    logic       RSP_ZERO;
    logic [7:0] ALU_DATA1, ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;
    logic       ALU_ZERO;

    int n_cmp = 0;
    int n_mis = 0;

    alu_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_OP    (REQ0_OP),
        .REQ0_A     (REQ0_A),
        .REQ0_B     (REQ0_B),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_OP    (REQ1_OP),
        .REQ1_A     (REQ1_A),
        .REQ1_B     (REQ1_B),
        .RSP0_VALID (RSP0_VALID),
        .RSP0_READY (RSP0_READY),
        .RSP1_VALID (RSP1_VALID),
        .RSP1_READY (RSP1_READY),
        .RSP_RESULT (RSP_RESULT),
        .RSP_ZERO   (RSP_ZERO),
        .ALU_DATA1  (ALU_DATA1),
        .ALU_DATA2  (ALU_DATA2),
        .ALU_SELECT (ALU_SELECT),
        .ALU_RESULT (ALU_RESULT),
        .ALU_ZERO   (ALU_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU; code 7 returns a recognisable constant.
    always_comb begin
        ALU_RESULT = 8'h00;
        case (ALU_SELECT)
            3'd0: ALU_RESULT = ALU_DATA1;
            3'd1: ALU_RESULT = ALU_DATA1 + ALU_DATA2;
            3'd2: ALU_RESULT = ALU_DATA1 & ALU_DATA2;
            3'd3: ALU_RESULT = ALU_DATA1 | ALU_DATA2;
            3'd4: ALU_RESULT = ALU_DATA1 * ALU_DATA2;
            3'd5: ALU_RESULT = ALU_DATA1 << ALU_DATA2;
            3'd6: ALU_RESULT = ALU_DATA1 >> ALU_DATA2;
            default: ALU_RESULT = 8'hAA;
        endcase
        ALU_ZERO = (ALU_RESULT == 8'h00);
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive_req(input int n, input logic v, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            REQ0_VALID = v; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
        end else begin
            REQ1_VALID = v; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
        end
    endtask

    // One complete transaction from requester n with its RSP_READY held high.
    task automatic run_op(input string tag, input int n, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b, input int lat,
                          input logic [7:0] exp_r, input logic exp_z);
        logic rdy_n, rdy_o, vld_n, vld_o;
        RSP0_READY = 1'b1;
        RSP1_READY = 1'b1;
        drive_req(n, 1'b1, op, a, b);
        #1;
        rdy_n = (n == 0) ? REQ0_READY : REQ1_READY;
        rdy_o = (n == 0) ? REQ1_READY : REQ0_READY;
        check($sformatf("%s_ready", tag), 32'(rdy_n), 32'd1);
        check($sformatf("%s_ready_other", tag), 32'(rdy_o), 32'd0);
        for (int i = 0; i < lat; i++) begin
            cyc();
            if (i == 0) drive_req(n, 1'b0, 3'd0, ~a, ~b);
            #1;
            vld_n = (n == 0) ? RSP0_VALID : RSP1_VALID;
            check($sformatf("%s_sel_c%0d", tag, i), 32'(ALU_SELECT), 32'(op));
            check($sformatf("%s_d1_c%0d", tag, i), 32'(ALU_DATA1), 32'(a));
            check($sformatf("%s_d2_c%0d", tag, i), 32'(ALU_DATA2), 32'(b));
            check($sformatf("%s_early_vld_c%0d", tag, i), 32'(vld_n), 32'd0);
        end
        cyc();
        vld_n = (n == 0) ? RSP0_VALID : RSP1_VALID;
        vld_o = (n == 0) ? RSP1_VALID : RSP0_VALID;
        check($sformatf("%s_rsp_vld", tag), 32'(vld_n), 32'd1);
        check($sformatf("%s_rsp_vld_other", tag), 32'(vld_o), 32'd0);
        check($sformatf("%s_result", tag), 32'(RSP_RESULT), 32'(exp_r));
        check($sformatf("%s_zero", tag), 32'(RSP_ZERO), 32'(exp_z));
        cyc();
        vld_n = (n == 0) ? RSP0_VALID : RSP1_VALID;
        check($sformatf("%s_rsp_done", tag), 32'(vld_n), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_req0_rdy", tag), 32'(REQ0_READY), 32'd0);
        check($sformatf("%s_req1_rdy", tag), 32'(REQ1_READY), 32'd0);
        check($sformatf("%s_rsp0_vld", tag), 32'(RSP0_VALID), 32'd0);
        check($sformatf("%s_rsp1_vld", tag), 32'(RSP1_VALID), 32'd0);
        check($sformatf("%s_result", tag), 32'(RSP_RESULT), 32'd0);
        check($sformatf("%s_zero", tag), 32'(RSP_ZERO), 32'd0);
        check($sformatf("%s_d1", tag), 32'(ALU_DATA1), 32'd0);
        check($sformatf("%s_d2", tag), 32'(ALU_DATA2), 32'd0);
        check($sformatf("%s_sel", tag), 32'(ALU_SELECT), 32'd0);
    endtask

    initial begin
        int g, last, cycles;

        RESET = 1'b0;
        drive_req(0, 1'b1, 3'd1, 8'h11, 8'h22);
        drive_req(1, 1'b1, 3'd1, 8'h33, 8'h44);
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b0;
        cyc();
        cyc();
        check_all_zero("reset");
        drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        RESET = 1'b1;
        cyc();

        // Basic, multi-cycle and shift ops; results hand-computed.
        run_op("add",  0, 3'd1, 8'h05, 8'h03, 1, 8'h08, 1'b0);
        run_op("mult", 0, 3'd4, 8'h03, 8'h04, 3, 8'h0C, 1'b0);
        run_op("sl",   1, 3'd5, 8'h01, 8'h02, 2, 8'h04, 1'b0);
        run_op("and",  0, 3'd2, 8'hF0, 8'h0F, 1, 8'h00, 1'b1);
        run_op("op7",  0, 3'd7, 8'h12, 8'h34, 1, 8'hAA, 1'b0);

        // Backpressure on requester 1 while requester 0 waits.
        RSP1_READY = 1'b0;
        RSP0_READY = 1'b1;
        drive_req(1, 1'b1, 3'd1, 8'h10, 8'h20);
        #1;
        check("bp_accept", 32'(REQ1_READY), 32'd1);
        cyc();
        drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        drive_req(0, 1'b1, 3'd0, 8'h5A, 8'h00);
        #1;
        check("bp_exec_rdy0", 32'(REQ0_READY), 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_vld_%0d", i), 32'(RSP1_VALID), 32'd1);
            check($sformatf("bp_res_%0d", i), 32'(RSP_RESULT), 32'h30);
            check($sformatf("bp_zero_%0d", i), 32'(RSP_ZERO), 32'd0);
            check($sformatf("bp_rdy0_%0d", i), 32'(REQ0_READY), 32'd0);
            check($sformatf("bp_rdy1_%0d", i), 32'(REQ1_READY), 32'd0);
            cyc();
        end
        RSP1_READY = 1'b1;
        #1;
        check("bp_hold_last", 32'(RSP1_VALID), 32'd1);
        cyc();
        check("bp_resume_rdy0", 32'(REQ0_READY), 32'd1);
        check("bp_rsp1_cleared", 32'(RSP1_VALID), 32'd0);
        cyc();
        drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        cyc();
        check("fwd_vld", 32'(RSP0_VALID), 32'd1);
        check("fwd_res", 32'(RSP_RESULT), 32'h5A);
        cyc();

        // Asynchronous reset in the middle of a MULT.
        drive_req(0, 1'b1, 3'd4, 8'h03, 8'h04);
        #1;
        check("abort_accept", 32'(REQ0_READY), 32'd1);
        cyc();
        drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        #3;
        RESET = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("abort_no_rsp0_%0d", i), 32'(RSP0_VALID), 32'd0);
        end
        RESET = 1'b1;
        cyc();
        check("abort_no_rsp0_after", 32'(RSP0_VALID), 32'd0);
        run_op("post_abort", 1, 3'd1, 8'h01, 8'h01, 1, 8'h02, 1'b0);

        // Fresh reset, then both requesters contend continuously.
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        cyc();
        RSP0_READY = 1'b1;
        RSP1_READY = 1'b1;
        drive_req(0, 1'b1, 3'd1, 8'h01, 8'h01);
        drive_req(1, 1'b1, 3'd1, 8'h02, 8'h02);
        g = 0;
        last = -1;
        cycles = 0;
        while (g < 4 && cycles < 40) begin
            #1;
            if (REQ0_READY || REQ1_READY) begin
                check($sformatf("rr_excl_%0d", g), 32'(REQ0_READY & REQ1_READY), 32'd0);
                check($sformatf("rr_who_%0d", g), 32'(REQ1_READY), 32'(g % 2));
                if (g > 0) check($sformatf("rr_gap_%0d", g), 32'(cycles - last), 32'd3);
                last = cycles;
                g++;
            end
            cyc();
            cycles++;
        end
        check("rr_grants", 32'(g), 32'd4);
        drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
